store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/global_types.sv | 13 +
 rtl/store_buffer_if.sv | 37 +++
 rtl/store_buffer_fifo.sv | 55 +++++
 rtl/store_buffer.sv | 122 ++++++++++++
 tb/tb_store_buffer.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/global_types.sv
// Shared types and default sizing for the store buffer.
// Entry address field is SB_AW wide; instances use AW <= SB_AW.
package global_types;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 10;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [31:0]      data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Core-side store/load ports and data-memory port of the store buffer.
// master = core/memory environment, slave = store_buffer.
interface store_buffer_if
  import global_types::*;
#(
  parameter int AW = SB_AW
) ();

  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;
  logic          st_ready;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic          ld_stall;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wd;
  logic [31:0]   mem_rd;
  logic          empty;

  modport master (
    output st_valid, st_addr, st_data,
    output ld_valid, ld_addr, mem_rd,
    input  st_ready, ld_data, ld_stall,
    input  mem_we, mem_addr, mem_wd, empty
  );

  modport slave (
    input  st_valid, st_addr, st_data,
    input  ld_valid, ld_addr, mem_rd,
    output st_ready, ld_data, ld_stall,
    output mem_we, mem_addr, mem_wd, empty
  );

endinterface

// File: rtl/store_buffer_fifo.sv
// sb_fifo: circular storage of pending stores with head/tail/count.
// Entries are not reset; only pointers and count are cleared.
module sb_fifo
  import global_types::*;
#(
  parameter int DEPTH = SB_DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  sb_entry_t     push_entry_i,
  output sb_entry_t     head_entry_o,
  output logic [PW-1:0] head_o,
  output logic [CW-1:0] count_o,
  output sb_entry_t     entries_o [DEPTH]
);

  sb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) tail_q <= tail_q + PW'(1);
      if (pop_i)  head_q <= head_q + PW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[tail_q] <= push_entry_i;
  end

  assign head_entry_o = mem_q[head_q];
  assign head_o       = head_q;
  assign count_o      = count_q;
  assign entries_o    = mem_q;

endmodule

// File: rtl/store_buffer.sv
// Store buffer: memory-port arbitration and load/store hazard handling.
// Define STORE_BUFFER_FWD_EN to forward pending store data to loads.
module store_buffer
  import global_types::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW
) (
  input logic           clock,
  input logic           reset,
  store_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  sb_entry_t     head_e;
  sb_entry_t     entries [DEPTH];
  sb_entry_t     push_e;
  logic [PW-1:0] head;
  logic [CW-1:0] count;
  logic [PW-1:0] idx;
  logic          push, pop;
  logic          full, starve;
  logic          ld_sel, dr_sel;
  logic          hit;
`ifdef STORE_BUFFER_FWD_EN
  logic [31:0]   fwd_data;
`endif

  sb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i        (clock),
    .rst_ni       (reset),
    .push_i       (push),
    .pop_i        (pop),
    .push_entry_i (push_e),
    .head_entry_o (head_e),
    .head_o       (head),
    .count_o      (count),
    .entries_o    (entries)
  );

  assign push_e.addr = SB_AW'(bus.st_addr);
  assign push_e.data = bus.st_data;

  assign full   = (count == CW'(DEPTH));
  assign starve = full && bus.st_valid;
  assign ld_sel = !starve && bus.ld_valid;
  assign dr_sel = !starve && !bus.ld_valid && (count != '0);

  // Oldest-to-youngest scan, so the last match is the youngest.
  always_comb begin
    hit = 1'b0;
    idx = '0;
`ifdef STORE_BUFFER_FWD_EN
    fwd_data = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count &&
          entries[idx].addr == SB_AW'(bus.ld_addr)) begin
        hit = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
        fwd_data = entries[idx].data;
`endif
      end
    end
  end

  always_comb begin
    bus.st_ready = 1'b1;
    bus.empty    = 1'b1;
    bus.mem_we   = 1'b0;
    bus.mem_addr = '0;
    bus.mem_wd   = '0;
    bus.ld_data  = '0;
    bus.ld_stall = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    if (reset) begin
      bus.st_ready = !full;
      bus.empty    = (count == '0);
      push         = bus.st_valid && !full;
      unique case (1'b1)
        starve: begin
          bus.ld_stall = bus.ld_valid;
          bus.mem_we   = 1'b1;
          bus.mem_addr = AW'(head_e.addr);
          bus.mem_wd   = head_e.data;
          pop          = 1'b1;
        end
        ld_sel: begin
`ifdef STORE_BUFFER_FWD_EN
          bus.mem_addr = bus.ld_addr;
          bus.ld_data  = hit ? fwd_data : bus.mem_rd;
`else
          if (hit) begin
            bus.ld_stall = 1'b1;
            bus.mem_we   = 1'b1;
            bus.mem_addr = AW'(head_e.addr);
            bus.mem_wd   = head_e.data;
            pop          = 1'b1;
          end else begin
            bus.mem_addr = bus.ld_addr;
            bus.ld_data  = bus.mem_rd;
          end
`endif
        end
        dr_sel: begin
          bus.mem_we   = 1'b1;
          bus.mem_addr = AW'(head_e.addr);
          bus.mem_wd   = head_e.data;
          pop          = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: queue-based reference model
// of pending stores plus a flat reference memory.
module tb_store_buffer;
  import global_types::*;

  localparam int DEPTH = SB_DEPTH;
  localparam int AW    = SB_AW;
  localparam int MW    = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_buffer_if #(.AW(AW)) bus ();

  store_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] pat(input logic [AW-1:0] a);
    return 32'h5A00_0000 ^ ({22'd0, a} * 32'h9E37_79B1);
  endfunction

  logic [31:0] phys  [MW];
  bit          wflag [MW];
  assign bus.mem_rd = wflag[bus.mem_addr] ?
                      phys[bus.mem_addr] : pat(bus.mem_addr);
  always @(posedge clk) begin
    if (bus.mem_we) begin
      phys[bus.mem_addr]  <= bus.mem_wd;
      wflag[bus.mem_addr] <= 1'b1;
    end
  end

  typedef struct {
    bit          st_ready;
    bit          empty;
    bit          mem_we;
    bit          ld_stall;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] ld_data;
  } exp_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } ent_t;

  exp_t        exp_q [$];
  ent_t        mq [$];
  logic [31:0] ref_mem [MW];
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("st_ready", 32'(bus.st_ready), 32'(e.st_ready));
      chk("empty",    32'(bus.empty),    32'(e.empty));
      chk("mem_we",   32'(bus.mem_we),   32'(e.mem_we));
      chk("ld_stall", 32'(bus.ld_stall), 32'(e.ld_stall));
      chk("mem_addr", 32'(bus.mem_addr), 32'(e.mem_addr));
      chk("mem_wd",   bus.mem_wd,        e.mem_wd);
      chk("ld_data",  bus.ld_data,       e.ld_data);
    end
  end

  // One cycle: drive inputs, predict outputs, advance the model.
  task automatic step(input bit r, input bit sv,
                      input logic [AW-1:0] sa, input logic [31:0] sd,
                      input bit lv, input logic [AW-1:0] la,
                      output bit stall);
    exp_t        e;
    int          n;
    bit          full, hit, drain;
    logic [31:0] fd;
    @(posedge clk);
    #1;
    rst_n        = r;
    bus.st_valid = sv;
    bus.st_addr  = sa;
    bus.st_data  = sd;
    bus.ld_valid = lv;
    bus.ld_addr  = la;
    e = '{st_ready: 1'b1, empty: 1'b1, mem_we: 1'b0, ld_stall: 1'b0,
          mem_addr: '0, mem_wd: '0, ld_data: '0};
    if (!r) begin
      mq.delete();
    end else begin
      n     = mq.size();
      full  = (n == DEPTH);
      hit   = 1'b0;
      fd    = '0;
      drain = 1'b0;
      for (int i = 0; i < n; i++)
        if (mq[i].a == la) begin
          hit = 1'b1;
          fd  = mq[i].d;
        end
      e.st_ready = !full;
      e.empty    = (n == 0);
      if (full && sv) begin
        drain      = 1'b1;
        e.ld_stall = lv;
      end else if (lv) begin
`ifdef STORE_BUFFER_FWD_EN
        e.mem_addr = la;
        e.ld_data  = hit ? fd : ref_mem[la];
`else
        if (hit) begin
          drain      = 1'b1;
          e.ld_stall = 1'b1;
        end else begin
          e.mem_addr = la;
          e.ld_data  = ref_mem[la];
        end
`endif
      end else if (n > 0) begin
        drain = 1'b1;
      end
      if (drain) begin
        e.mem_we   = 1'b1;
        e.mem_addr = mq[0].a;
        e.mem_wd   = mq[0].d;
        ref_mem[mq[0].a] = mq[0].d;
        void'(mq.pop_front());
      end
      if (sv && !full) mq.push_back('{sa, sd});
    end
    stall = e.ld_stall;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    bit s;
    for (int i = 0; i < n; i++) step(1, 0, '0, '0, 0, '0, s);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit          s;
    bit          lv;
    bit          r;
    logic [AW-1:0] la;
    for (int i = 0; i < MW; i++) ref_mem[i] = pat(AW'(i));
    bus.st_valid = 1'b0;
    bus.st_addr  = '0;
    bus.st_data  = '0;
    bus.ld_valid = 1'b0;
    bus.ld_addr  = '0;

    step(0, 0, '0, '0, 0, '0, s);
    step(0, 0, '0, '0, 0, '0, s);
    idle(1);

    step(1, 1, 10'h010, 32'hDEAD_BEEF, 0, '0, s);
    idle(3);

    step(1, 1, 10'h020, 32'h11, 1, 10'h3F0, s);
    step(1, 1, 10'h020, 32'h22, 1, 10'h3F0, s);
    step(1, 0, '0, '0, 1, 10'h020, s);
    step(1, 0, '0, '0, 1, 10'h020, s);
    idle(4);

    for (int i = 0; i < 4; i++)
      step(1, 1, AW'(10'h100 + i), 32'hA0 + i, 1, 10'h3F0, s);
    step(1, 1, 10'h104, 32'hA4, 1, 10'h3F0, s);
    step(1, 1, 10'h105, 32'hA5, 1, 10'h3F0, s);
    idle(6);

    step(1, 1, 10'h030, 32'hC0FF_EE00, 1, 10'h3F1, s);
    step(1, 0, '0, '0, 1, 10'h030, s);
    step(1, 0, '0, '0, 1, 10'h030, s);
    idle(2);

    for (int i = 0; i < 6; i++)
      step(1, 1, AW'(10'h040 + i), 32'hB0 + i, (i % 3) != 2, 10'h3F2, s);
    step(0, 0, '0, '0, 0, '0, s);
    step(0, 0, '0, '0, 0, '0, s);
    idle(4);

    s  = 1'b0;
    lv = 1'b0;
    la = '0;
    for (int k = 0; k < 1500; k++) begin
      r = ($urandom_range(99) != 0);
      if (!s) begin
        lv = 1'($urandom_range(1));
        la = AW'(10'h010 + $urandom_range(7));
      end
      step(r, 1'($urandom_range(1)),
           AW'(10'h010 + $urandom_range(7)), $urandom,
           r ? lv : 1'b0, la, s);
      if (!r) s = 1'b0;
    end
    idle(8);

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
